// File: rtl/or_and_tree_pipe.sv
// or_and_tree_pipe: pipelined alternating OR/AND reduction of (x & y).
//
// Each tree level has its own register stage. Stage 0 holds the leaf AND
// vector, and stage k holds tree level k. Every stage carries a valid bit and
// the mode bit of its transaction, so mode may change on every transaction.
// All stages advance together when the output is not stalled. Bubbles are not
// compressed.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  input handshake (in_ready is combinational)
//   x, y                 N-bit operands
//   mode                 0: OR on odd levels / AND on even; 1: swapped
//   out_valid / out_ready, z   registered result handshake
//   cnt_clr              synchronous clear of hit_cnt (beats increment)
//   hit_cnt              saturating count of delivered z=1 results
module or_and_tree_pipe #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             z,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int LEVELS = $clog2(N);
  localparam int TW     = 2 * N - 1;

  // All levels are packed into one vector. Level k (width N>>k) starts at
  // bit 2N - 2*(N>>k), so level 0 is [N-1:0] and the root is bit TW-1.
  logic [TW-1:0]     r_tree;
  logic [TW-1:0]     w_tree;
  logic [LEVELS:0]   r_vld;
  logic [LEVELS-1:0] r_mode;
  logic [LEVELS-1:0] w_mode;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_en;
  logic              w_hit;

  assign w_en     = !(r_vld[LEVELS] && !out_ready);
  assign in_ready = w_en;

  assign w_tree[N-1:0] = x & y;
  assign w_mode[0]     = mode;

  genvar k, j;
  generate
    for (k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int W = N >> k;
      localparam int O = 2 * N - 2 * W;
      localparam int P = 2 * N - 4 * W;
      logic w_and;

      // Level k is computed from stage k-1, so it uses that stage's mode.
      if (k % 2 == 1) begin : g_odd
        assign w_and = r_mode[k-1];
      end else begin : g_even
        assign w_and = !r_mode[k-1];
      end

      for (j = 0; j < W; j++) begin : g_node
        assign w_tree[O+j] = w_and ? (r_tree[P+2*j] & r_tree[P+2*j+1])
                                   : (r_tree[P+2*j] | r_tree[P+2*j+1]);
      end

      if (k < LEVELS) begin : g_mode
        assign w_mode[k] = r_mode[k-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tree <= '0;
      r_vld  <= '0;
      r_mode <= '0;
    end else if (w_en) begin
      r_tree <= w_tree;
      r_vld  <= {r_vld[LEVELS-1:0], in_valid};
      r_mode <= w_mode;
    end
  end

  assign w_hit = r_vld[LEVELS] && out_ready && r_tree[TW-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_hit && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_vld[LEVELS];
  assign z         = r_tree[TW-1];
  assign hit_cnt   = r_cnt;

endmodule

// File: doc/or_and_tree_pipe.md
Name: or_and_tree_pipe

Overview:
Pipelined, parametrised alternating OR/AND reduction tree over the bitwise AND of two N-bit operands.
- Each tree level has its own register stage, so the block closes timing at large N.
- A valid/ready handshake on input and output supports backpressure.
- A per-transaction mode bit selects which operator sits on odd levels.
- A saturating hit counter records how many delivered results were 1.
- Sits in the datapath as the registered replacement for the combinational or_and_tree.

Parameters:
N, 8, operand width; power of two, N >= 2
LEVELS, $clog2(N), number of tree levels (derived; not overridable)
CNT_W, 16, width of the hit counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input transaction valid
in_ready  output  1  block accepts input this cycle
x  input  N  operand X
y  input  N  operand Y
mode  input  1  0: OR on odd levels / AND on even; 1: AND on odd / OR on even
out_valid  output  1  z valid
out_ready  input  1  downstream accepts z
z  output  1  reduction result
cnt_clr  input  1  synchronous clear of hit_cnt
hit_cnt  output  CNT_W  number of delivered results with z=1, saturating

Behaviour:
- Function:
  - Leaf level 0: L0[i] = x[i] & y[i].
  - Level k (1..LEVELS) combines the pair (2j, 2j+1) of level k-1 into element j.
  - Odd k uses OR when mode=0 and AND when mode=1; even k uses the other operator.
  - z = L_LEVELS[0].
- Pipeline:
  - Stage 0 registers L0 and mode. Stage k registers level k and mode.
  - Each stage has a valid bit. mode travels with its data, so mode may change on every transaction.
- Advance enable: en = !(out_valid && !out_ready). in_ready = en, which is combinational from out_valid/out_ready.
- Accept: an input is accepted on a rising edge where in_valid && in_ready.
  - When en=1, every stage loads from its predecessor.
  - Stage 0 valid loads in_valid.
  - Bubbles propagate; they are not compressed.
- When en=0 all stage data and valid bits hold.
- Latency: a result accepted at edge t appears on z with out_valid=1 after edge t+LEVELS.
  - Example: N=8 gives 3 edges.
  - Throughput is 1 per cycle when out_ready=1.
- z and out_valid come directly from the last stage register. There is no combinational path from x/y to z.
- Hold rule: while out_valid=1 and out_ready=0, z and out_valid stay stable until the transfer completes.
- hit_cnt:
  - Increments by 1 on each edge where out_valid && out_ready && z.
  - Holds at 2^CNT_W-1; it never wraps.
  - cnt_clr=1 sets it to 0 on the next edge and takes priority over a simultaneous increment.
- Reset (asserted at any time, including mid-stream):
  - All stage valid bits, data registers and hit_cnt go to 0 immediately.
  - out_valid=0, z=0, hit_cnt=0.
  - in_ready=1 once out_valid=0.
  - In-flight transactions are discarded.
- Release of rst takes effect at the first subsequent rising edge. No transaction is accepted while rst=1.
- N=2 (LEVELS=1): a single OR (mode 0) or AND (mode 1) of the two leaf bits. Latency is 1 edge after accept.

Test Plan:
- N=8, mode=0, x=FF y=FF, out_ready=1 -> z=1, out_valid=1 exactly 3 edges after accept; hit_cnt=1. Same with x=00 -> z=0, hit_cnt unchanged.
- N=4: x=5 y=5 mode=0 -> z=1; same operands with mode=1 on the next cycle -> z=0. Results appear back-to-back on consecutive cycles in order.
- N=8, mode=0, x=0F y=FF -> z=1. x=AA y=AA -> level 1 gives 1111, level 2 gives 11, z=1. x=01 y=01 -> z=0.
- Backpressure: stream 5 transactions, hold out_ready=0 for 4 cycles -> in_ready=0 while out_valid=1; z stable; no loss or duplication; after release, all 5 results arrive in order.
- Counter: CNT_W=2, deliver 5 results with z=1 -> hit_cnt saturates at 3. Assert cnt_clr together with a z=1 delivery -> hit_cnt=0.
- Reset mid-stream with 3 transactions in flight -> out_valid=0 and hit_cnt=0 immediately. After release, no stale results appear; a new x=FF y=FF gives z=1 after LEVELS edges.
